// File: rtl/mdr_mem_responder.sv
// Memory-side responder for the CPU datapath's memory data register.
// It captures a single-cycle read/write request, waits WAIT_CYCLES
// cycles, performs the RAM access and then pulses mem_ack for one cycle.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   mem_req      request pulse, sampled only while ready=1
//   mem_we       1 = write, 0 = read (qualified by mem_req)
//   addr         word address from the MAR (qualified by mem_req)
//   data_bus_in  write data from the MDR (qualified by mem_req)
//   data_bus_out read data to the MDR; holds the last value read
//   mem_ack      one-cycle completion strobe for reads and writes
//   ready        idle and able to accept a request
//   overrun      sticky: a request arrived while ready=0
module mdr_mem_responder #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic [DATA_WIDTH-1:0] data_bus_out,
  output logic                  mem_ack,
  output logic                  ready,
  output logic                  overrun
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ovr_q, ovr_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Access port: driven on the edge that enters ACK
  logic                  acc_c;
  logic                  acc_we_c;
  logic [ADDR_WIDTH-1:0] acc_addr_c;
  logic [DATA_WIDTH-1:0] acc_wdata_c;

  // Next-state, capture and access decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ovr_d       = ovr_q;
    acc_c       = 1'b0;
    acc_we_c    = we_q;
    acc_addr_c  = addr_q;
    acc_wdata_c = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          addr_d  = addr;
          we_d    = mem_we;
          wdata_d = data_bus_in;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES != 0) begin
            state_d = S_WAIT;
          end else begin
            // Zero wait states: access straight from the request inputs
            state_d     = S_ACK;
            acc_c       = 1'b1;
            acc_we_c    = mem_we;
            acc_addr_c  = addr;
            acc_wdata_c = data_bus_in;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_ACK;
          cnt_d   = '0;
          acc_c   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (acc_c && !acc_we_c) begin
      rdata_d = mem_q[acc_addr_c];
    end

    // Any request outside IDLE is dropped and flagged
    if (mem_req && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  // Control and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ovr_q   <= ovr_d;
    end
  end

  // RAM array; contents survive reset, but a reset edge suppresses the write
  always_ff @(posedge clk) begin
    if (rst_n && acc_c && acc_we_c) begin
      mem_q[acc_addr_c] <= acc_wdata_c;
    end
  end

  assign ready        = (state_q == S_IDLE);
  assign mem_ack      = (state_q == S_ACK);
  assign data_bus_out = rdata_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_mdr_mem_responder.sv
// Bench for mdr_mem_responder: three instances (2, 0 and 5 wait states)
// driven by directed scenarios and randomized transactions, checked
// against a transaction-level memory model.
module tb_mdr_mem_responder;

  logic       clk;
  logic       rst_n;
  logic       req   [3];
  logic       we    [3];
  logic [7:0] addr  [3];
  logic [7:0] din   [3];
  wire  [7:0] dout  [3];
  wire        ack   [3];
  wire        rdy   [3];
  wire        ovr   [3];

  int         wc [3] = '{2, 0, 5};

  logic [7:0] mem_m    [3][256];
  logic [7:0] exp_dout [3];
  logic       exp_ovr  [3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mdr_mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .mem_req(req[0]), .mem_we(we[0]), .addr(addr[0]),
    .data_bus_in(din[0]), .data_bus_out(dout[0]), .mem_ack(ack[0]),
    .ready(rdy[0]), .overrun(ovr[0]));

  mdr_mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .mem_req(req[1]), .mem_we(we[1]), .addr(addr[1]),
    .data_bus_in(din[1]), .data_bus_out(dout[1]), .mem_ack(ack[1]),
    .ready(rdy[1]), .overrun(ovr[1]));

  mdr_mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_CYCLES(5)) u2 (
    .clk(clk), .rst_n(rst_n), .mem_req(req[2]), .mem_we(we[2]), .addr(addr[2]),
    .data_bus_in(din[2]), .data_bus_out(dout[2]), .mem_ack(ack[2]),
    .ready(rdy[2]), .overrun(ovr[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic scramble(input int i);
    we[i]   = 1'($urandom);
    addr[i] = 8'($urandom);
    din[i]  = 8'($urandom);
  endtask

  // One transaction on instance i, started at a negedge while idle.
  // mode 0: plain; 1: extra write request one cycle after capture;
  // 2: request fields randomized every cycle after capture.
  task automatic txn(input int i, input bit w, input logic [7:0] a,
                     input logic [7:0] d, input int mode);
    int n;
    check("ready_before_req", 32'(rdy[i]), 32'd1);
    req[i] = 1'b1; we[i] = w; addr[i] = a; din[i] = d;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    req[i] = 1'b0;
    if (mode == 1) begin
      req[i] = 1'b1; we[i] = 1'b1; addr[i] = 8'h20; din[i] = 8'hFF;
      exp_ovr[i] = 1'b1;
    end
    if (mode == 2) scramble(i);
    while (ack[i] !== 1'b1 && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      req[i] = 1'b0;
      if (mode == 2) scramble(i);
    end
    check("ack_latency", 32'(n), 32'(wc[i] + 1));
    if (w) mem_m[i][a] = d;
    else   exp_dout[i] = mem_m[i][a];
    check("dout_at_ack", 32'(dout[i]), 32'(exp_dout[i]));
    check("ready_at_ack", 32'(rdy[i]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req[i] = 1'b0;
    check("ack_one_cycle", 32'(ack[i]), 32'd0);
    check("ready_after_ack", 32'(rdy[i]), 32'd1);
    check("overrun", 32'(ovr[i]), 32'(exp_ovr[i]));
    check("dout_hold", 32'(dout[i]), 32'(exp_dout[i]));
  endtask

  initial begin
    bit saw_ack;
    int i;

    // Reset with requests asserted
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b1; we[k] = 1'b1; addr[k] = 8'h01; din[k] = 8'h55;
      exp_dout[k] = 8'h00; exp_ovr[k] = 1'b0;
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", 32'(rdy[k]), 32'd1);
      check("rst_ack", 32'(ack[k]), 32'd0);
      check("rst_overrun", 32'(ovr[k]), 32'd0);
      check("rst_dout", 32'(dout[k]), 32'd0);
      req[k] = 1'b0;
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Write then back-to-back read, 2 wait states
    txn(0, 1'b1, 8'h10, 8'hA5, 0);
    txn(0, 1'b0, 8'h10, 8'h00, 0);

    // Latency sweep with 0 and 5 wait states
    for (int k = 1; k < 3; k++) begin
      txn(k, 1'b1, 8'h30, 8'h3C, 0);
      txn(k, 1'b0, 8'h30, 8'h00, 0);
    end

    // Overrun during WAIT must not write 0xFF to 0x20
    txn(0, 1'b1, 8'h20, 8'h5A, 0);
    txn(0, 1'b0, 8'h10, 8'h00, 1);
    txn(0, 1'b0, 8'h20, 8'h00, 0);

    // Request during the ack cycle is an overrun
    txn(1, 1'b0, 8'h30, 8'h00, 1);

    // Reset in the middle of a write aborts it
    txn(0, 1'b1, 8'h05, 8'h11, 0);
    check("ready_before_req", 32'(rdy[0]), 32'd1);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h05; din[0] = 8'h77;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_dout[k] = 8'h00; exp_ovr[k] = 1'b0;
      check("midrst_overrun", 32'(ovr[k]), 32'd0);
    end
    saw_ack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (ack[0] === 1'b1) saw_ack = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_ack", 32'(saw_ack), 32'd0);
    txn(0, 1'b0, 8'h05, 8'h00, 0);

    // Request fields toggling after capture must not disturb a read
    txn(0, 1'b1, 8'h40, 8'h9E, 0);
    txn(0, 1'b0, 8'h40, 8'h00, 2);
    txn(0, 1'b0, 8'h40, 8'h00, 0);
    txn(0, 1'b0, 8'h10, 8'h00, 0);

    // Preload a window for randomized traffic
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 16; j++)
        txn(k, 1'b1, 8'(8'hE0 + j), 8'($urandom), 0);

    // Randomized mixed traffic
    for (int r = 0; r < 60; r++) begin
      int mode;
      i = int'($urandom_range(2, 0));
      mode = ($urandom_range(7, 0) == 0) ? 1 : (($urandom_range(3, 0) == 0) ? 2 : 0);
      txn(i, 1'($urandom), 8'(8'hE0 + $urandom_range(15, 0)), 8'($urandom), mode);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
